// File: rtl/uart_rx.sv
// 8N1 UART receiver: 2-flop input synchroniser, 3-sample mid-bit majority vote,
// valid/ready byte output with one-cycle frame_err and overrun pulses.
`timescale 1ns/1ps
module uart_rx #(
  parameter int CLK_HZ = 12000000,
  parameter int BAUD   = 115200
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rx,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  input  logic       rx_ready,
  output logic       frame_err,
  output logic       overrun
);

  localparam int CLKS_PER_BIT = (CLK_HZ + BAUD / 2) / BAUD;
  localparam int MID          = CLKS_PER_BIT / 2;
  localparam int CNT_W        = $clog2(CLKS_PER_BIT);

  if (CLKS_PER_BIT < 8) begin : g_bad_baud
    $error("uart_rx: CLKS_PER_BIT must be at least 8");
  end

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_STOP,
    S_WAIT_IDLE
  } state_t;

  logic             r_sync1;
  logic             r_sync2;
  state_t           r_state;
  logic [CNT_W-1:0] r_cnt;
  logic [2:0]       r_bit_idx;
  logic [7:0]       r_shift;
  logic             r_s0;
  logic             r_s1;
  logic [7:0]       r_rx_data;
  logic             r_rx_valid;
  logic             r_frame_err;
  logic             r_overrun;

  logic w_rx_s;
  logic w_maj;
  logic w_decide;
  logic w_last;

  assign w_rx_s   = r_sync2;
  // Third sample is the live synchronised line at the decision cycle.
  assign w_maj    = (r_s0 & r_s1) | (r_s0 & w_rx_s) | (r_s1 & w_rx_s);
  assign w_decide = (r_cnt == CNT_W'(MID + 1));
  assign w_last   = (r_cnt == CNT_W'(CLKS_PER_BIT - 1));

  // NOTE: synchroniser flops reset to the idle line level (1) so leaving reset
  // never looks like a start bit.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_sync1 <= 1'b1;
      r_sync2 <= 1'b1;
    end else begin
      r_sync1 <= rx;
      r_sync2 <= r_sync1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_cnt       <= '0;
      r_bit_idx   <= '0;
      r_shift     <= '0;
      r_s0        <= 1'b1;
      r_s1        <= 1'b1;
      r_rx_data   <= '0;
      r_rx_valid  <= 1'b0;
      r_frame_err <= 1'b0;
      r_overrun   <= 1'b0;
    end else begin
      r_frame_err <= 1'b0;
      r_overrun   <= 1'b0;
      // NOTE: a byte loaded in STOP below overrides this clear (last assignment wins).
      if (r_rx_valid && rx_ready) r_rx_valid <= 1'b0;
      if (r_cnt == CNT_W'(MID - 1)) r_s0 <= w_rx_s;
      if (r_cnt == CNT_W'(MID))     r_s1 <= w_rx_s;

      case (r_state)
        S_IDLE: begin
          r_cnt <= '0;
          if (!w_rx_s) r_state <= S_START;
        end
        S_START: begin
          if (w_decide && w_maj) begin
            r_cnt   <= '0;
            r_state <= S_IDLE;
          end else if (w_last) begin
            r_cnt     <= '0;
            r_bit_idx <= '0;
            r_state   <= S_DATA;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        S_DATA: begin
          if (w_decide) r_shift <= {w_maj, r_shift[7:1]};
          if (w_last) begin
            r_cnt <= '0;
            if (r_bit_idx == 3'd7) r_state   <= S_STOP;
            else                   r_bit_idx <= r_bit_idx + 1'b1;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        S_STOP: begin
          // Decide mid stop bit so a back-to-back start edge is not missed.
          if (w_decide) begin
            r_cnt <= '0;
            if (w_maj) begin
              if (!r_rx_valid || rx_ready) begin
                r_rx_data  <= r_shift;
                r_rx_valid <= 1'b1;
              end else begin
                r_overrun <= 1'b1;
              end
              r_state <= S_IDLE;
            end else begin
              r_frame_err <= 1'b1;
              r_state     <= S_WAIT_IDLE;
            end
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        S_WAIT_IDLE: begin
          r_cnt <= '0;
          if (w_rx_s) r_state <= S_IDLE;
        end
        default: begin
          r_cnt   <= '0;
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign rx_data   = r_rx_data;
  assign rx_valid  = r_rx_valid;
  assign frame_err = r_frame_err;
  assign overrun   = r_overrun;

endmodule

// File: tb/tb_uart_rx.sv
// Self-checking bench for uart_rx: serial line driver, scoreboard queue of
// expected bytes popped on each valid/ready handshake, per-scenario tasks.
`timescale 1ns/1ps
module tb_uart_rx;

  localparam int CPB     = 104;
  localparam int MID     = 52;
  localparam int LATENCY = 992;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       rx = 1'b1;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       rx_ready = 1'b0;
  logic       frame_err;
  logic       overrun;

  int checks = 0;
  int errors = 0;
  int n_hs   = 0;
  int n_rise = 0;
  int n_ferr = 0;
  int n_ovr  = 0;
  logic prev_v = 1'b0;
  logic abort_tx = 1'b0;
  logic [7:0] exp_q[$];

  uart_rx dut (
    .clk      (clk),
    .rst      (rst),
    .rx       (rx),
    .rx_data  (rx_data),
    .rx_valid (rx_valid),
    .rx_ready (rx_ready),
    .frame_err(frame_err),
    .overrun  (overrun)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached, got no finish, required finish");
    $fatal(1, "watchdog");
  end

  // Scoreboard monitor: samples on the falling edge, away from the active edge.
  always @(negedge clk) begin
    if (!rst) begin
      if (rx_valid && !prev_v) n_rise++;
      if (frame_err) n_ferr++;
      if (overrun)   n_ovr++;
      if (frame_err || overrun) begin
        checks++;
        if (frame_err && overrun) begin
          errors++;
          $display("FAIL pulse_exclusive: got frame_err=1 overrun=1, required not both");
        end
      end
      if (rx_valid && rx_ready) begin
        n_hs++;
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL handshake_unexpected: got byte %02h, required no delivery", rx_data);
        end else begin
          automatic logic [7:0] e = exp_q.pop_front();
          if (rx_data !== e) begin
            errors++;
            $display("FAIL handshake_data: got %02h, required %02h", rx_data, e);
          end
        end
      end
    end
    prev_v = rx_valid;
  end

  // Callers are aligned 1 ns after a rising edge; each cycle k of a bit is
  // sampled by the DUT on the k-th rising edge.
  task automatic send_bit(input logic v, input int glitch_k);
    for (int k = 0; k < CPB; k++) begin
      rx = abort_tx ? 1'b1 : ((k == glitch_k) ? ~v : v);
      @(posedge clk);
      #1;
    end
  endtask

  task automatic send_frame(input logic [7:0] b, input logic stop_v, input int glitch_k);
    send_bit(1'b0, -1);
    for (int i = 0; i < 8; i++) send_bit(b[i], glitch_k);
    send_bit(stop_v, -1);
  endtask

  task automatic wait_cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic pulse_ready();
    rx_ready = 1'b1;
    @(posedge clk);
    #1;
    rx_ready = 1'b0;
  endtask

  task automatic cmp(input string name, input logic [31:0] got, input logic [31:0] req);
    checks++;
    if (got !== req) begin
      errors++;
      $display("FAIL %s: got %0h, required %0h", name, got, req);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    wait_cycles(3);
    checks++;
    if (rx_data !== 8'h00 || rx_valid !== 1'b0 || frame_err !== 1'b0 || overrun !== 1'b0) begin
      errors++;
      $display("FAIL reset_outputs: got data=%02h v=%b fe=%b ov=%b, required all 0",
               rx_data, rx_valid, frame_err, overrun);
    end
    rst = 1'b0;
    wait_cycles(5);
  endtask

  task automatic test_single_byte();
    int n = 0;
    rx_ready = 1'b0;
    exp_q.push_back(8'h48);
    fork
      send_frame(8'h48, 1'b1, -1);
      begin
        @(posedge clk);
        while (n < 1200) begin
          @(posedge clk);
          n++;
          #1;
          if (rx_valid) break;
        end
      end
    join
    cmp("single_latency", n, LATENCY);
    wait_cycles(100);
    cmp("single_held_valid", rx_valid, 1'b1);
    cmp("single_data", rx_data, 8'h48);
    pulse_ready();
    cmp("single_valid_cleared", rx_valid, 1'b0);
  endtask

  task automatic test_stream();
    logic [7:0] msg [15] = '{8'h48, 8'h65, 8'h6C, 8'h6C, 8'h6F, 8'h2C, 8'h20, 8'h77,
                             8'h6F, 8'h72, 8'h6C, 8'h64, 8'h21, 8'h0A, 8'h0D};
    int hs0 = n_hs, r0 = n_rise, f0 = n_ferr, o0 = n_ovr;
    rx_ready = 1'b1;
    for (int i = 0; i < 15; i++) exp_q.push_back(msg[i]);
    for (int i = 0; i < 15; i++) send_frame(msg[i], 1'b1, -1);
    wait_cycles(20);
    cmp("stream_handshakes", n_hs - hs0, 15);
    cmp("stream_valid_pulses", n_rise - r0, 15);
    cmp("stream_frame_err", n_ferr - f0, 0);
    cmp("stream_overrun", n_ovr - o0, 0);
    cmp("stream_queue_empty", exp_q.size(), 0);
    rx_ready = 1'b0;
  endtask

  task automatic test_framing();
    int r0 = n_rise, f0 = n_ferr, o0 = n_ovr, hs0 = n_hs;
    rx_ready = 1'b0;
    send_frame(8'h55, 1'b0, -1);
    cmp("framing_err_pulse", n_ferr - f0, 1);
    cmp("framing_no_valid", n_rise - r0, 0);
    rx = 1'b0;
    wait_cycles(2000);
    cmp("framing_low_hold_err", n_ferr - f0, 1);
    cmp("framing_low_hold_valid", n_rise - r0, 0);
    cmp("framing_low_hold_ovr", n_ovr - o0, 0);
    rx = 1'b1;
    wait_cycles(50);
    rx_ready = 1'b1;
    exp_q.push_back(8'hA5);
    send_frame(8'hA5, 1'b1, -1);
    wait_cycles(20);
    cmp("framing_recover_hs", n_hs - hs0, 1);
    cmp("framing_recover_queue", exp_q.size(), 0);
    rx_ready = 1'b0;
  endtask

  task automatic test_noise();
    int r0 = n_rise, f0 = n_ferr, o0 = n_ovr, hs0 = n_hs;
    rx = 1'b0;
    wait_cycles(20);
    rx = 1'b1;
    wait_cycles(300);
    cmp("noise_idle_valid", n_rise - r0, 0);
    cmp("noise_idle_events", (n_ferr - f0) + (n_ovr - o0), 0);
    rx_ready = 1'b1;
    exp_q.push_back(8'h3C);
    send_frame(8'h3C, 1'b1, MID + 1);
    wait_cycles(20);
    cmp("noise_glitch_hs", n_hs - hs0, 1);
    cmp("noise_glitch_ferr", n_ferr - f0, 0);
    rx_ready = 1'b0;
  endtask

  task automatic test_overrun();
    int r0 = n_rise, f0 = n_ferr, o0 = n_ovr;
    rx_ready = 1'b0;
    send_frame(8'h11, 1'b1, -1);
    send_frame(8'h22, 1'b1, -1);
    cmp("overrun_pulse", n_ovr - o0, 1);
    cmp("overrun_data_kept", rx_data, 8'h11);
    cmp("overrun_valid", rx_valid, 1'b1);
    cmp("overrun_no_ferr", n_ferr - f0, 0);
    exp_q.push_back(8'h11);
    pulse_ready();
    cmp("overrun_consumed", rx_valid, 1'b0);

    o0 = n_ovr;
    r0 = n_rise;
    exp_q.push_back(8'h11);
    exp_q.push_back(8'h22);
    send_frame(8'h11, 1'b1, -1);
    fork
      send_frame(8'h22, 1'b1, -1);
      begin
        repeat (LATENCY) @(posedge clk);
        #1 rx_ready = 1'b1;
        @(posedge clk);
        #1 rx_ready = 1'b0;
      end
    join
    cmp("ready_at_stop_data", rx_data, 8'h22);
    cmp("ready_at_stop_valid", rx_valid, 1'b1);
    cmp("ready_at_stop_no_ovr", n_ovr - o0, 0);
    cmp("ready_at_stop_rises", n_rise - r0, 1);
    pulse_ready();
    cmp("ready_at_stop_queue", exp_q.size(), 0);
  endtask

  task automatic test_reset_mid_frame();
    int r0 = n_rise, hs0 = n_hs;
    rx_ready = 1'b0;
    fork
      send_frame(8'h3C, 1'b1, -1);
      begin
        repeat (5 * CPB + 50) @(posedge clk);
        #1;
        rst = 1'b1;
        abort_tx = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        checks++;
        if (rx_data !== 8'h00 || rx_valid !== 1'b0 || frame_err !== 1'b0 || overrun !== 1'b0) begin
          errors++;
          $display("FAIL midframe_reset_outputs: got data=%02h v=%b fe=%b ov=%b, required all 0",
                   rx_data, rx_valid, frame_err, overrun);
        end
      end
    join
    abort_tx = 1'b0;
    wait_cycles(1200);
    cmp("midframe_no_delivery", n_rise - r0, 0);
    rx_ready = 1'b1;
    exp_q.push_back(8'hC3);
    send_frame(8'hC3, 1'b1, -1);
    wait_cycles(20);
    cmp("midframe_recover_hs", n_hs - hs0, 1);
    rx_ready = 1'b0;
  endtask

  initial begin
    test_reset();
    test_single_byte();
    test_stream();
    test_framing();
    test_noise();
    test_overrun();
    test_reset_mid_frame();
    cmp("final_queue_empty", exp_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
